// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, cond-field evaluation and write-strobe gating.
// Optional saturating exec/squash statistics counters are built when COND_STATS_EN is defined.
module cond_logic #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       aluFlags,
  input  logic [1:0]       flagW,
  input  logic             PCS,
  input  logic             regW,
  input  logic             memW,
  output logic             condEx,
  output logic             PCSrc,
  output logic             regWrite,
  output logic             memWrite,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] execCount,
  output logic [CNT_W-1:0] squashCount
);

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } condCode_e;

  condCode_e code;
  logic      flagN, flagZ, flagC, flagV;
  logic      commit;

  assign code = condCode_e'(cond);
  assign {flagN, flagZ, flagC, flagV} = flags;

  always_comb begin
    condEx = 1'b0;
    case (code)
      EQ: condEx = flagZ;
      NE: condEx = ~flagZ;
      CS: condEx = flagC;
      CC: condEx = ~flagC;
      MI: condEx = flagN;
      PL: condEx = ~flagN;
      VS: condEx = flagV;
      VC: condEx = ~flagV;
      HI: condEx = flagC & ~flagZ;
      LS: condEx = ~flagC | flagZ;
      GE: condEx = (flagN == flagV);
      LT: condEx = (flagN != flagV);
      GT: condEx = ~flagZ & (flagN == flagV);
      LE: condEx = flagZ | (flagN != flagV);
      AL: condEx = 1'b1;
      NV: condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end

  assign commit = en & condEx;

  // rst_n in the gate keeps strobes low for the whole async reset window
  assign PCSrc    = PCS  & commit & rst_n;
  assign regWrite = regW & commit & rst_n;
  assign memWrite = memW & commit & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= RESET_FLAGS;
    end else if (commit) begin
      if (flagW[1]) flags[3:2] <= aluFlags[3:2];
      if (flagW[0]) flags[1:0] <= aluFlags[1:0];
    end
  end

`ifdef COND_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      execCount   <= '0;
      squashCount <= '0;
    end else if (en) begin
      if (condEx) begin
        if (execCount != '1) execCount <= execCount + 1'b1;
      end else begin
        if (squashCount != '1) squashCount <= squashCount + 1'b1;
      end
    end
  end
`else
  assign execCount   = '0;
  assign squashCount = '0;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: directed vectors push expectations, a negedge monitor checks them.
module tb_cond_logic;

  localparam int unsigned CW = 4;

  logic          clk, rst_n, en, PCS, regW, memW;
  logic [3:0]    cond, aluFlags;
  logic [1:0]    flagW;
  logic          condEx, PCSrc, regWrite, memWrite;
  logic [3:0]    flags;
  logic [CW-1:0] execCount, squashCount;

  cond_logic #(.CNT_W(CW), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .aluFlags(aluFlags),
    .flagW(flagW), .PCS(PCS), .regW(regW), .memW(memW),
    .condEx(condEx), .PCSrc(PCSrc), .regWrite(regWrite), .memWrite(memWrite),
    .flags(flags), .execCount(execCount), .squashCount(squashCount)
  );

  typedef struct {
    logic       rstN, en, pulse;
    logic [3:0] cond, alu;
    logic [1:0] flagW;
    logic       pcs, regW, memW;
    logic       expCond;
    logic [3:0] expFlags;
  } vec_t;

  typedef struct {
    logic          condEx, pcSrc, regWrite, memWrite;
    logic [3:0]    flags;
    logic [CW-1:0] exec, squash;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("condEx",      {3'b0, condEx},   {3'b0, e.condEx});
      check("PCSrc",       {3'b0, PCSrc},    {3'b0, e.pcSrc});
      check("regWrite",    {3'b0, regWrite}, {3'b0, e.regWrite});
      check("memWrite",    {3'b0, memWrite}, {3'b0, e.memWrite});
      check("flags",       flags,            e.flags);
      check("execCount",   execCount,        e.exec);
      check("squashCount", squashCount,      e.squash);
    end
  end

  vec_t vecs[$];

  function automatic vec_t mk(input logic rstN, input logic en_, input logic pulse,
                              input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                              input logic p, input logic r, input logic m,
                              input logic ec, input logic [3:0] ef);
    vec_t v;
    v.rstN = rstN; v.en = en_; v.pulse = pulse; v.cond = c; v.alu = a; v.flagW = fw;
    v.pcs = p; v.regW = r; v.memW = m; v.expCond = ec; v.expFlags = ef;
    return v;
  endfunction

  initial begin
    int unsigned mExec, mSquash;
    exp_t e;
    mExec = 0; mSquash = 0;
    rst_n = 1'b0; en = 1'b1; cond = 4'b0000; aluFlags = '0; flagW = '0;
    PCS = 1'b1; regW = 1'b0; memW = 1'b0;

    //              rst en pl cond     alu      fw     P  R  M  cEx flags(before edge)
    vecs.push_back(mk(0, 1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 1, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 4'b0001, 4'b1001, 2'b11, 0, 0, 1, 0, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b1011, 2'b01, 0, 0, 0, 1, 4'b0100));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 1, 4'b0111));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, 1, 4'b0111));
    vecs.push_back(mk(1, 1, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1111, 4'b0000, 2'b11, 1, 0, 0, 0, 4'b1001));
    vecs.push_back(mk(1, 0, 0, 4'b1110, 4'b0110, 2'b11, 1, 1, 1, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b0110, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b1001));
    vecs.push_back(mk(1, 1, 0, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 4'b1001));
    vecs.push_back(mk(0, 0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 1, 4'b0000));
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 1, 4'b0000));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rstN; en = vecs[i].en; cond = vecs[i].cond;
      aluFlags = vecs[i].alu; flagW = vecs[i].flagW;
      PCS = vecs[i].pcs; regW = vecs[i].regW; memW = vecs[i].memW;
      if (vecs[i].pulse) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      if (!vecs[i].rstN || vecs[i].pulse) begin
        mExec = 0; mSquash = 0;
      end
      e.condEx   = vecs[i].expCond;
      e.pcSrc    = vecs[i].pcs  & vecs[i].expCond & vecs[i].en & vecs[i].rstN;
      e.regWrite = vecs[i].regW & vecs[i].expCond & vecs[i].en & vecs[i].rstN;
      e.memWrite = vecs[i].memW & vecs[i].expCond & vecs[i].en & vecs[i].rstN;
      e.flags    = vecs[i].expFlags;
`ifdef COND_STATS_EN
      e.exec   = CW'(mExec);
      e.squash = CW'(mSquash);
`else
      e.exec   = '0;
      e.squash = '0;
`endif
      sb.push_back(e);
      if (vecs[i].rstN && vecs[i].en) begin
        if (vecs[i].expCond) begin
          if (mExec < 15) mExec++;
        end else begin
          if (mSquash < 15) mSquash++;
        end
      end
    end

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
